multdiv_sequencer: RTL and testbench

Multi-cycle multiply/divide unit and its sequencer for the 5-stage pipelined processor. It accepts a MUL or DIV issued from the DX stage, runs an iterative 32-step engine, and holds the pipeline stall high until the result is ready. It then presents the result, destination register and exception flag for one cycle so the pipeline can carry them into XM.

---
 rtl/multdiv_sequencer_pkg.sv | 20 ++
 rtl/multdiv_engine.sv | 67 ++++++
 rtl/multdiv_sequencer.sv | 156 +++++++++++++++
 tb/tb_multdiv_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// ALU opcodes that issue to it, sequencer state encoding, and the
// rstatus codes the pipeline writes when the unit raises an exception.
package multdiv_sequencer_pkg;

  localparam int unsigned ALU_OP_W = 5;
  localparam logic [ALU_OP_W-1:0] ALU_OP_MUL = 5'b00110;
  localparam logic [ALU_OP_W-1:0] ALU_OP_DIV = 5'b00111;

  localparam int unsigned RSTATUS_W = 32;
  localparam logic [RSTATUS_W-1:0] RSTATUS_MUL_OVF  = 32'd4;
  localparam logic [RSTATUS_W-1:0] RSTATUS_DIV_ZERO = 32'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multdiv_engine.sv
// Iterative unsigned multiply / restoring-divide datapath, one bit per step.
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   load                  load magnitudes: lo <= a_mag, m <= b_mag, hi <= 0
//   step                  perform one iteration (shift-add or shift-subtract)
//   is_div                selects divide step when high, multiply step when low
//   a_mag, b_mag          operand magnitudes (multiplicand/dividend, multiplier/divisor)
//   product_nxt           {hi,lo} as it will be after the current step
//   quotient_nxt          lo as it will be after the current step
// The "next" outputs let the sequencer register its result on the same edge
// that retires the final step.
module multdiv_engine #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     a_mag,
  input  logic [WIDTH-1:0]     b_mag,
  output logic [2*WIDTH-1:0]   product_nxt,
  output logic [WIDTH-1:0]     quotient_nxt
);

  logic [WIDTH-1:0] hi, lo, m;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;

  // Single iteration of either algorithm
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    div_rem  = {hi, lo[WIDTH-1]};
    div_diff = div_rem - {1'b0, m};
    // Shifted remainder < 2*m, so the borrow bit alone tells whether m fits
    div_ok   = ~div_diff[WIDTH];
    if (is_div) begin
      hi_nxt = div_ok ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], div_ok};
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    end
    product_nxt  = {hi_nxt, lo_nxt};
    quotient_nxt = lo_nxt;
  end

  // Accumulator / shift registers
  always_ff @(posedge clock) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
      m  <= '0;
    end else if (load) begin
      hi <= '0;
      lo <= a_mag;
      m  <= b_mag;
    end else if (step) begin
      hi <= hi_nxt;
      lo <= lo_nxt;
    end
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Multi-cycle MUL/DIV sequencer for the 5-stage pipeline. Accepts an issue
// from DX, stalls the front of the pipe while the engine iterates WIDTH
// times, then presents result/result_reg/exception for one cycle.
// Ports:
//   clock, reset             clock and synchronous active-high reset
//   start_mult, start_div    issue signed multiply / divide (mult wins if both)
//   operand_a, operand_b     rs (multiplicand/dividend), rt (multiplier/divisor)
//   dest_reg                 rd of the issuing instruction
//   flush                    squash the in-flight operation
//   stall                    combinational freeze of PC/FD/DX
//   busy                     registered, high while iterating
//   result_valid             registered one-cycle pulse in DONE
//   result, result_reg       low product word or quotient, captured rd
//   exception                mult overflow or divide by zero
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned REG_BITS = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start_mult,
  input  logic                start_div,
  input  logic [WIDTH-1:0]    operand_a,
  input  logic [WIDTH-1:0]    operand_b,
  input  logic [REG_BITS-1:0] dest_reg,
  input  logic                flush,
  output logic                stall,
  output logic                busy,
  output logic                result_valid,
  output logic [WIDTH-1:0]    result,
  output logic [REG_BITS-1:0] result_reg,
  output logic                exception
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;

  logic [CNT_W-1:0]    cnt;
  logic                op_div;
  logic                neg_res;
  logic [REG_BITS-1:0] dest_q;

  logic                start_any, start_is_div, div_by_zero;
  logic                sign_a, sign_b;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic                eng_load, eng_step;
  logic [PW-1:0]       product_nxt, prod_signed;
  logic [WIDTH-1:0]    quotient_nxt, quot_signed;
  logic                mul_ovf;

  // Issue decode and operand magnitudes
  always_comb begin
    start_any    = start_mult | start_div;
    start_is_div = start_div & ~start_mult;
    sign_a       = operand_a[WIDTH-1];
    sign_b       = operand_b[WIDTH-1];
    a_mag        = sign_a ? (~operand_a + WIDTH'(1)) : operand_a;
    b_mag        = sign_b ? (~operand_b + WIDTH'(1)) : operand_b;
    div_by_zero  = start_is_div && (operand_b == '0);
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and engine control
  always_comb begin
    state_nxt = state;
    eng_load  = 1'b0;
    eng_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_any && !flush) begin
          eng_load  = 1'b1;
          state_nxt = div_by_zero ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_nxt = ST_IDLE;
        end else begin
          eng_step = 1'b1;
          if (cnt == CNT_LAST) state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Issuing instruction must stay in DX from the cycle it is seen
  assign stall = ((state == ST_IDLE) && start_any && !flush) || (state == ST_RUN);

  multdiv_engine #(.WIDTH(WIDTH)) u_engine (
    .clock        (clock),
    .reset        (reset),
    .load         (eng_load),
    .step         (eng_step),
    .is_div       (op_div),
    .a_mag        (a_mag),
    .b_mag        (b_mag),
    .product_nxt  (product_nxt),
    .quotient_nxt (quotient_nxt)
  );

  // Sign fix-up and overflow: the product fits when bits [PW-1:WIDTH-1] agree
  always_comb begin
    prod_signed = neg_res ? (~product_nxt + PW'(1)) : product_nxt;
    quot_signed = neg_res ? (~quotient_nxt + WIDTH'(1)) : quotient_nxt;
    mul_ovf     = !((&prod_signed[PW-1:WIDTH-1]) || !(|prod_signed[PW-1:WIDTH-1]));
  end

  // Counter, captured op info and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt          <= '0;
      op_div       <= 1'b0;
      neg_res      <= 1'b0;
      dest_q       <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      result_reg   <= '0;
      exception    <= 1'b0;
    end else begin
      busy         <= (state_nxt == ST_RUN);
      result_valid <= (state_nxt == ST_DONE);
      if (eng_load) begin
        cnt     <= '0;
        op_div  <= start_is_div;
        neg_res <= sign_a ^ sign_b;
        dest_q  <= dest_reg;
      end else if (eng_step) begin
        cnt <= cnt + CNT_W'(1);
      end
      if ((state == ST_IDLE) && (state_nxt == ST_DONE)) begin
        // Divide by zero short-circuits the engine
        result     <= '0;
        exception  <= 1'b1;
        result_reg <= dest_reg;
      end else if ((state == ST_RUN) && (state_nxt == ST_DONE)) begin
        result     <= op_div ? quot_signed : prod_signed[WIDTH-1:0];
        exception  <= op_div ? 1'b0 : mul_ovf;
        result_reg <= dest_q;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed self-checking bench for multdiv_sequencer.
module tb_multdiv_sequencer;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned REG_BITS = 5;

  logic                clock = 1'b0;
  logic                reset;
  logic                start_mult, start_div, flush;
  logic [WIDTH-1:0]    operand_a, operand_b;
  logic [REG_BITS-1:0] dest_reg;
  logic                stall, busy, result_valid, exception;
  logic [WIDTH-1:0]    result;
  logic [REG_BITS-1:0] result_reg;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clock = ~clock;

  multdiv_sequencer #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) dut (
    .clock        (clock),
    .reset        (reset),
    .start_mult   (start_mult),
    .start_div    (start_div),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .dest_reg     (dest_reg),
    .flush        (flush),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .result_reg   (result_reg),
    .exception    (exception)
  );

  // Issue one op in the next cycle (cycle 0), scramble inputs afterwards,
  // and observe until result_valid (bounded).
  task automatic issue_and_wait(input logic is_div, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic [REG_BITS-1:0] rd,
                                output int lat, output int stall_cnt, output int busy_cnt,
                                output logic stall_done, output logic [WIDTH-1:0] res,
                                output logic exc, output logic [REG_BITS-1:0] rr);
    int cyc;
    lat = -1; stall_cnt = 0; busy_cnt = 0; stall_done = 1'b1;
    res = '0; exc = 1'b0; rr = '0;
    @(posedge clock); #1;
    start_mult = !is_div; start_div = is_div;
    operand_a = a; operand_b = b; dest_reg = rd;
    cyc = 0;
    while (lat < 0 && cyc < 40) begin
      @(negedge clock);
      if (result_valid) begin
        lat = cyc; res = result; exc = exception; rr = result_reg; stall_done = stall;
      end else begin
        if (stall) stall_cnt++;
        if (busy)  busy_cnt++;
      end
      if (lat < 0) begin
        @(posedge clock); #1;
        start_mult = 1'b0; start_div = 1'b0;
        operand_a = ~a; operand_b = ~b; dest_reg = ~rd;
        cyc++;
      end
    end
    start_mult = 1'b0; start_div = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; flush = 1'b0;
    operand_a = '0; operand_b = '0; dest_reg = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk_cnt++;
    if ({stall, busy, result_valid, exception, result, result_reg} !== '0)
      $display("FAIL reset_outputs: got stall=%b busy=%b valid=%b exc=%b res=%h rr=%h want all 0",
               stall, busy, result_valid, exception, result, result_reg);
    else pass_cnt++;
  endtask

  task automatic test_mul();
    logic [WIDTH-1:0] va [5] = '{32'd7, 32'hFFFFFFFD, 32'h00010000, 32'h80000000, 32'h80000000};
    logic [WIDTH-1:0] vb [5] = '{32'd6, 32'd5,        32'h00010000, 32'd1,        32'hFFFFFFFF};
    logic [WIDTH-1:0] vr [5] = '{32'd42, 32'hFFFFFFF1, 32'h0,       32'h80000000, 32'h80000000};
    logic             ve [5] = '{1'b0,  1'b0,         1'b1,         1'b0,         1'b1};
    int lat, sc, bc; logic sd, exc; logic [WIDTH-1:0] res; logic [REG_BITS-1:0] rr;
    for (int i = 0; i < 5; i++) begin
      issue_and_wait(1'b0, va[i], vb[i], REG_BITS'(i + 3), lat, sc, bc, sd, res, exc, rr);
      chk_cnt++;
      if (res !== vr[i]) $display("FAIL mul_result[%0d]: got %h want %h", i, res, vr[i]);
      else pass_cnt++;
      chk_cnt++;
      if (exc !== ve[i]) $display("FAIL mul_exception[%0d]: got %b want %b", i, exc, ve[i]);
      else pass_cnt++;
      chk_cnt++;
      if (rr !== REG_BITS'(i + 3)) $display("FAIL mul_result_reg[%0d]: got %0d want %0d", i, rr, i + 3);
      else pass_cnt++;
      chk_cnt++;
      if (lat != 33 || sc != 33 || bc != 32 || sd !== 1'b0)
        $display("FAIL mul_timing[%0d]: got lat=%0d stall=%0d busy=%0d stall_done=%b want 33/33/32/0",
                 i, lat, sc, bc, sd);
      else pass_cnt++;
    end
    // Pulse ends and the result fields hold
    @(posedge clock); @(negedge clock);
    chk_cnt++;
    if (result_valid !== 1'b0 || result !== 32'h80000000 || exception !== 1'b1 || result_reg !== 5'd7)
      $display("FAIL mul_hold: got valid=%b res=%h exc=%b rr=%0d want 0/80000000/1/7",
               result_valid, result, exception, result_reg);
    else pass_cnt++;
  endtask

  task automatic test_div();
    logic [WIDTH-1:0] va [5] = '{32'd100, 32'hFFFFFF9C, 32'h80000000, 32'd7,        32'd0};
    logic [WIDTH-1:0] vb [5] = '{32'd7,   32'd7,        32'hFFFFFFFF, 32'hFFFFFFFE, 32'd5};
    logic [WIDTH-1:0] vr [5] = '{32'd14,  32'hFFFFFFF2, 32'h80000000, 32'hFFFFFFFD, 32'd0};
    int lat, sc, bc; logic sd, exc; logic [WIDTH-1:0] res; logic [REG_BITS-1:0] rr;
    for (int i = 0; i < 5; i++) begin
      issue_and_wait(1'b1, va[i], vb[i], REG_BITS'(20 + i), lat, sc, bc, sd, res, exc, rr);
      chk_cnt++;
      if (res !== vr[i] || exc !== 1'b0)
        $display("FAIL div_result[%0d]: got %h exc=%b want %h exc=0", i, res, exc, vr[i]);
      else pass_cnt++;
      chk_cnt++;
      if (rr !== REG_BITS'(20 + i) || lat != 33)
        $display("FAIL div_reg_lat[%0d]: got rr=%0d lat=%0d want %0d/33", i, rr, lat, 20 + i);
      else pass_cnt++;
    end
  endtask

  task automatic test_div_zero();
    int lat, sc, bc; logic sd, exc; logic [WIDTH-1:0] res; logic [REG_BITS-1:0] rr;
    issue_and_wait(1'b1, 32'd5, 32'd0, 5'd11, lat, sc, bc, sd, res, exc, rr);
    chk_cnt++;
    if (res !== 32'd0 || exc !== 1'b1 || rr !== 5'd11)
      $display("FAIL div0_result: got res=%h exc=%b rr=%0d want 0/1/11", res, exc, rr);
    else pass_cnt++;
    chk_cnt++;
    if (lat != 1 || sc != 1 || bc != 0 || sd !== 1'b0)
      $display("FAIL div0_timing: got lat=%0d stall=%0d busy=%0d stall_done=%b want 1/1/0/0",
               lat, sc, bc, sd);
    else pass_cnt++;
    @(posedge clock); @(negedge clock);
    chk_cnt++;
    if (result_valid !== 1'b0 || stall !== 1'b0 || exception !== 1'b1)
      $display("FAIL div0_after: got valid=%b stall=%b exc=%b want 0/0/1", result_valid, stall, exception);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    int lat, sc, bc; logic sd, exc; logic [WIDTH-1:0] res; logic [REG_BITS-1:0] rr;
    logic seen;
    @(posedge clock); #1;
    start_mult = 1'b1; operand_a = 32'd7; operand_b = 32'd6; dest_reg = 5'd9;
    @(posedge clock); #1 start_mult = 1'b0;
    repeat (9) @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    @(negedge clock);
    chk_cnt++;
    if (stall !== 1'b0 || busy !== 1'b0)
      $display("FAIL flush_run_idle: got stall=%b busy=%b want 0/0", stall, busy);
    else pass_cnt++;
    seen = 1'b0;
    repeat (40) begin @(negedge clock); if (result_valid) seen = 1'b1; end
    chk_cnt++;
    if (seen !== 1'b0) $display("FAIL flush_no_valid: got pulse=%b want 0", seen);
    else pass_cnt++;
    // Flush together with a start in IDLE drops the start
    @(posedge clock); #1;
    start_div = 1'b1; flush = 1'b1; operand_a = 32'd9; operand_b = 32'd3; dest_reg = 5'd2;
    @(negedge clock);
    chk_cnt++;
    if (stall !== 1'b0) $display("FAIL flush_idle_stall: got %b want 0", stall);
    else pass_cnt++;
    @(posedge clock); #1 start_div = 1'b0; flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(negedge clock); if (result_valid || busy) seen = 1'b1; end
    chk_cnt++;
    if (seen !== 1'b0) $display("FAIL flush_idle_ignored: got activity=%b want 0", seen);
    else pass_cnt++;
    issue_and_wait(1'b1, 32'd9, 32'd3, 5'd13, lat, sc, bc, sd, res, exc, rr);
    chk_cnt++;
    if (res !== 32'd3 || exc !== 1'b0 || rr !== 5'd13 || lat != 33)
      $display("FAIL flush_then_div: got res=%h exc=%b rr=%0d lat=%0d want 3/0/13/33", res, exc, rr, lat);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, sc, bc; logic sd, exc; logic [WIDTH-1:0] res; logic [REG_BITS-1:0] rr;
    @(posedge clock); #1;
    start_div = 1'b1; operand_a = 32'd1000; operand_b = 32'd10; dest_reg = 5'd17;
    @(posedge clock); #1 start_div = 1'b0;
    repeat (19) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk_cnt++;
    if ({stall, busy, result_valid, exception, result, result_reg} !== '0)
      $display("FAIL reset_mid_outputs: got stall=%b busy=%b valid=%b exc=%b res=%h rr=%h want all 0",
               stall, busy, result_valid, exception, result, result_reg);
    else pass_cnt++;
    issue_and_wait(1'b0, 32'd2, 32'd2, 5'd30, lat, sc, bc, sd, res, exc, rr);
    chk_cnt++;
    if (res !== 32'd4 || exc !== 1'b0 || rr !== 5'd30 || lat != 33)
      $display("FAIL reset_then_mul: got res=%h exc=%b rr=%0d lat=%0d want 4/0/30/33", res, exc, rr, lat);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, sc, bc; logic sd, exc; logic [WIDTH-1:0] res; logic [REG_BITS-1:0] rr;
    int cyc;
    logic got;
    // MUL with a stray start during RUN that must be ignored
    @(posedge clock); #1;
    start_mult = 1'b1; operand_a = 32'd11; operand_b = 32'd13; dest_reg = 5'd4;
    @(posedge clock); #1 start_mult = 1'b0;
    repeat (4) @(posedge clock);
    #1 start_div = 1'b1; operand_a = 32'd50; operand_b = 32'd5; dest_reg = 5'd8;
    @(posedge clock); #1 start_div = 1'b0;
    cyc = 6; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clock);
      if (result_valid) got = 1'b1;
      else begin @(posedge clock); #1; cyc++; end
    end
    chk_cnt++;
    if (!got || result !== 32'd143 || result_reg !== 5'd4 || cyc != 33)
      $display("FAIL b2b_first: got valid=%b res=%h rr=%0d cyc=%0d want 1/8f/4/33", got, result, result_reg, cyc);
    else pass_cnt++;
    // Next issue lands in the IDLE cycle right after DONE
    issue_and_wait(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 5'd5, lat, sc, bc, sd, res, exc, rr);
    chk_cnt++;
    if (res !== 32'd14 || exc !== 1'b0 || rr !== 5'd5 || lat != 33)
      $display("FAIL b2b_second: got res=%h exc=%b rr=%0d lat=%0d want e/0/5/33", res, exc, rr, lat);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
